// File: rtl/rng_pkg.sv
// rng_pkg: shared constants, FSM state type and the xorshift32 step for rng_arbiter.
// Latency: n/a (package only; step() is purely combinational).
// Backpressure: n/a.
package rng_pkg;

  // Reset seed. It also replaces a zero seed write, because the all-zero state is a fixed point.
  localparam logic [31:0] DEFAULT_SEED = 32'h1a2b3c4d;

  // xorshift32 shift amounts: left, right, left.
  localparam int SH_A = 13;
  localparam int SH_B = 17;
  localparam int SH_C = 5;

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } rng_state_e;

  // One full xorshift32 step. Each stage works on the previous stage's result.
  function automatic logic [31:0] step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << SH_A);
    t = t ^ (t >> SH_B);
    t = t ^ (t << SH_C);
    return t;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from ptr+1 and wrapping at N_REQ.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; whoever uses the grant decides whether it is taken.
// Ports: req (candidate vector), ptr (last served index) -> grant (one-hot),
//        grant_idx (binary index of the grant), any_grant.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    grant_idx,
  output logic             any_grant
);

  always_comb begin
    int          s;
    logic [PW-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    s         = 0;
    sel       = '0;
    // Offset 1 comes first and offset N_REQ comes last, so the previous winner has the lowest priority.
    for (int off = 1; off <= N_REQ; off++) begin
      s = int'(ptr) + off;
      if (s >= N_REQ) s = s - N_REQ;
      sel = PW'(s);
      if (!any_grant && req[sel]) begin
        any_grant      = 1'b1;
        grant[sel]     = 1'b1;
        grant_idx      = sel;
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: one xorshift32 state shared round-robin among N_REQ requesters, with runtime reseed.
// Latency: req sampled at edge k -> rvalid/rdata at edge k+1; one grant per cycle at most.
// Backpressure: req is a held level; the requester served last cycle is masked; seed_we and warmup stall all grants.
// Ports: clk, reset (async, active-high), req[N_REQ] -> rvalid[N_REQ] (one-hot pulse), rdata[32];
//        seed_we/seed_data[32] reload the state; busy is high during warmup; draw_cnt[32] counts grants.
// Optional macro RNG_WARMUP_EN: after reset or a seed load, WARMUP_CNT steps are discarded while busy is high.
module rng_arbiter #(
  parameter int          N_REQ      = 4,
  parameter logic [31:0] SEED       = 32'h1a2b3c4d,
  parameter int          WARMUP_CNT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] rvalid,
  output logic [31:0]      rdata,
  input  logic             seed_we,
  input  logic [31:0]      seed_data,
  output logic             busy,
  output logic [31:0]      draw_cnt
);
  import rng_pkg::*;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [31:0]      x;
  logic [PW-1:0]    ptr;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic             any_grant;
  logic             in_run;
  logic [31:0]      seed_val;

  // rvalid is still high for the requester served last cycle. Masking it prevents a second grant
  // before that requester has had a chance to drop req.
  assign eligible = req & ~rvalid;
  assign seed_val = (seed_data == 32'd0) ? SEED : seed_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

`ifdef RNG_WARMUP_EN
  localparam int WCW = (WARMUP_CNT > 0) ? $clog2(WARMUP_CNT + 1) : 1;

  rng_state_e     st;
  logic [WCW-1:0] warm_left;

  // Reset and every seed load restart the warmup with a full count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= (WARMUP_CNT == 0) ? RUN : WARMUP;
      warm_left <= WCW'(WARMUP_CNT);
    end else if (seed_we) begin
      st        <= (WARMUP_CNT == 0) ? RUN : WARMUP;
      warm_left <= WCW'(WARMUP_CNT);
    end else if (st == WARMUP) begin
      if (warm_left <= WCW'(1)) st <= RUN;
      warm_left <= warm_left - WCW'(1);
    end
  end

  assign in_run = (st == RUN);
  assign busy   = (st == WARMUP);
`else
  assign in_run = 1'b1;
  assign busy   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x        <= SEED;
      rvalid   <= '0;
      rdata    <= '0;
      draw_cnt <= '0;
      ptr      <= PW'(N_REQ - 1);  // requester 0 is searched first after reset
    end else begin
      rvalid <= '0;
      if (seed_we) begin
        // A seed load takes priority over a grant in the same cycle. Pending requests wait until the next edge.
        x        <= seed_val;
        draw_cnt <= '0;
      end else if (!in_run) begin
        x <= step(x);            // warmup steps are discarded and are not counted
      end else if (any_grant) begin
        rvalid   <= grant;
        rdata    <= x;           // the requester gets the pre-step value
        x        <= step(x);
        ptr      <= grant_idx;
        draw_cnt <= draw_cnt + 32'd1;
      end
    end
  end

endmodule
